// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - two-requester round-robin arbiter in front of an SPI SRAM master
module spi_mem_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int WBURST_EN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_en,
    input  logic [1:0]  req_wr,
    input  logic [47:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_rdy,
    output logic [7:0]  req_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rburst,
    output logic        mem_wburst,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        served_q, served_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_valid_q, last_valid_d;
    logic        last_wr_q, last_wr_d;
    logic [23:0] last_addr_q, last_addr_d;

    logic        granted;
    logic        gidx;
    logic        grant_change;
    logic        addr_seq;
    logic [8:0]  cnt_inc;
    logic [24:0] last_addr_inc;

    // Decode which requester currently owns the memory port
    always_comb begin
        granted = (state_q == ST_G0) || (state_q == ST_G1);
        gidx    = (state_q == ST_G1);
    end

    // Request mux toward the master; everything reads as zero when idle or held in reset
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 24'd0;
        mem_wdata = 8'd0;
        if (granted && rst_n) begin
            mem_en    = req_en[gidx];
            mem_wr    = req_wr[gidx];
            mem_addr  = gidx ? req_addr[47:24] : req_addr[23:0];
            mem_wdata = gidx ? req_wdata[15:8] : req_wdata[7:0];
        end
    end

    // Completion strobes, read-data broadcast and address-continuation hints
    always_comb begin
        req_rdy = 2'b00;
        if (rst_n && mem_rdy) begin
            req_rdy[0] = (state_q == ST_G0);
            req_rdy[1] = (state_q == ST_G1);
        end
        req_rdata = mem_rdata;
        // 25-bit sum so the top of the address space never chains into address 0
        last_addr_inc = {1'b0, last_addr_q} + 25'd1;
        addr_seq      = ({1'b0, mem_addr} == last_addr_inc);
        mem_rburst    = mem_en & ~mem_wr & last_valid_q & ~last_wr_q & addr_seq;
        mem_wburst    = (WBURST_EN != 0) & mem_en & mem_wr & last_valid_q & last_wr_q & addr_seq;
    end

    // Grant selection: round-robin from idle, burst-limited hand-over, release when the owner goes quiet
    always_comb begin
        state_d = state_q;
        cnt_inc = {1'b0, cnt_q} + 9'd1;
        case (state_q)
            ST_IDLE: begin
                // Until someone has been served, requester 0 wins a tie
                if (req_en == 2'b11) begin
                    state_d = (served_q && !ptr_q) ? ST_G1 : ST_G0;
                end else if (req_en[0]) begin
                    state_d = ST_G0;
                end else if (req_en[1]) begin
                    state_d = ST_G1;
                end
            end
            ST_G0, ST_G1: begin
                if (mem_rdy) begin
                    if (req_en[~gidx] && (cnt_inc >= MAX_BURST_W)) begin
                        state_d = gidx ? ST_G0 : ST_G1;
                    end
                end else if (!req_en[gidx]) begin
                    state_d = req_en[~gidx] ? (gidx ? ST_G0 : ST_G1) : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer, burst counter and last-transfer tracking; a grant change wipes the run history
    always_comb begin
        grant_change = (state_d != state_q);
        ptr_d        = ptr_q;
        served_d     = served_q;
        if (grant_change && granted) begin
            ptr_d    = gidx;
            served_d = 1'b1;
        end
        cnt_d = cnt_q;
        if (grant_change) begin
            cnt_d = 8'd0;
        end else if (mem_rdy && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        last_valid_d = last_valid_q;
        last_wr_d    = last_wr_q;
        last_addr_d  = last_addr_q;
        if (mem_rdy) begin
            last_valid_d = 1'b1;
            last_wr_d    = mem_wr;
            last_addr_d  = mem_addr;
        end
        if (grant_change) begin
            last_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            served_q     <= 1'b0;
            cnt_q        <= 8'd0;
            last_valid_q <= 1'b0;
            last_wr_q    <= 1'b0;
            last_addr_q  <= 24'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            served_q     <= served_d;
            cnt_q        <= cnt_d;
            last_valid_q <= last_valid_d;
            last_wr_q    <= last_wr_d;
            last_addr_q  <= last_addr_d;
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - randomized and directed bench for spi_mem_arbiter
module tb_spi_mem_arbiter;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_en;
    logic [1:0]  req_wr;
    logic [47:0] req_addr;
    logic [15:0] req_wdata;
    logic        mem_rdy;
    logic [7:0]  mem_rdata;

    logic [1:0]  req_rdy;
    logic [7:0]  req_rdata;
    logic        mem_en, mem_wr, mem_rburst, mem_wburst;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic [1:0]  b_req_rdy;
    logic [7:0]  b_req_rdata;
    logic        b_mem_en, b_mem_wr, b_mem_rburst, b_mem_wburst;
    logic [23:0] b_mem_addr;
    logic [7:0]  b_mem_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } req_t;

    typedef struct {
        int          own;
        bit          wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
        bit          rb;
        bit          wb;
    } cpl_t;

    req_t q0[$];
    req_t q1[$];
    cpl_t exp_q[$];
    cpl_t last_c;
    bit   have_last;

    always #5 clk = ~clk;

    spi_mem_arbiter #(.MAX_BURST(MAXB), .WBURST_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(req_rdy),
        .req_rdata(req_rdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rburst(mem_rburst),
        .mem_wburst(mem_wburst), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
    );

    spi_mem_arbiter dut_b (
        .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(b_req_rdy),
        .req_rdata(b_req_rdata), .mem_en(b_mem_en), .mem_wr(b_mem_wr),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rburst(b_mem_rburst),
        .mem_wburst(b_mem_wburst), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_en = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
        mem_rdy = 1'b0; mem_rdata = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic push_dir(input int own, input bit wr, input logic [23:0] addr,
                            input logic [7:0] wd, input bit rb, input bit wb);
        req_t r;
        cpl_t c;
        r.wr = wr; r.addr = addr; r.wdata = wd;
        c.own = own; c.wr = wr; c.addr = addr; c.wdata = wd; c.rb = rb; c.wb = wb;
        exp_q.push_back(c);
        if (own == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    // Reference: a continuation exists only between consecutive completions of one uninterrupted run
    task automatic model_add(input int own, input req_t r);
        cpl_t c;
        bit   seq;
        c.own = own; c.wr = r.wr; c.addr = r.addr; c.wdata = r.wdata;
        seq  = have_last && (last_c.own == own) && (int'(last_c.addr) + 1 == int'(r.addr));
        c.rb = seq && !last_c.wr && !r.wr;
        c.wb = seq && last_c.wr && r.wr;
        exp_q.push_back(c);
        last_c = c;
        have_last = 1'b1;
        if (own == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    // Requesters present queue heads; memory answers after 0..2 cycles; completions checked in order
    task automatic run_traffic(input string tag);
        int         lat;
        int         cyc;
        int         n;
        cpl_t       e;
        logic [1:0] exp_rdy;
        lat = $urandom_range(0, 2);
        cyc = 0;
        n   = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(posedge clk); #1;
            req_en = {q1.size() > 0, q0.size() > 0};
            if (q0.size() > 0) begin
                req_wr[0] = q0[0].wr; req_addr[23:0] = q0[0].addr; req_wdata[7:0] = q0[0].wdata;
            end
            if (q1.size() > 0) begin
                req_wr[1] = q1[0].wr; req_addr[47:24] = q1[0].addr; req_wdata[15:8] = q1[0].wdata;
            end
            mem_rdy = 1'b0;
            #1;
            if (mem_en === 1'b1) begin
                if (lat == 0) begin
                    mem_rdy   = 1'b1;
                    mem_rdata = 8'($urandom);
                    lat       = $urandom_range(0, 2);
                end else begin
                    lat--;
                end
            end
            @(negedge clk);
            if (mem_rdy) begin
                e = exp_q.pop_front();
                exp_rdy = (e.own == 0) ? 2'b01 : 2'b10;
                checks++;
                if (req_rdy !== exp_rdy) begin
                    errors++; $display("FAIL %s cpl%0d req_rdy got %b want %b", tag, n, req_rdy, exp_rdy);
                end
                checks++;
                if (mem_addr !== e.addr || mem_wr !== e.wr) begin
                    errors++; $display("FAIL %s cpl%0d addr/wr got %h/%b want %h/%b", tag, n, mem_addr, mem_wr, e.addr, e.wr);
                end
                if (e.wr) begin
                    checks++;
                    if (mem_wdata !== e.wdata) begin
                        errors++; $display("FAIL %s cpl%0d wdata got %h want %h", tag, n, mem_wdata, e.wdata);
                    end
                end
                checks++;
                if (req_rdata !== mem_rdata) begin
                    errors++; $display("FAIL %s cpl%0d rdata got %h want %h", tag, n, req_rdata, mem_rdata);
                end
                checks++;
                if (mem_rburst !== e.rb) begin
                    errors++; $display("FAIL %s cpl%0d rburst got %b want %b", tag, n, mem_rburst, e.rb);
                end
                checks++;
                if (mem_wburst !== e.wb) begin
                    errors++; $display("FAIL %s cpl%0d wburst got %b want %b", tag, n, mem_wburst, e.wb);
                end
                checks++;
                if (b_mem_wburst !== 1'b0) begin
                    errors++; $display("FAIL %s cpl%0d wburst_disabled got %b want 0", tag, n, b_mem_wburst);
                end
                if (req_rdy[0] === 1'b1 && q0.size() > 0) void'(q0.pop_front());
                if (req_rdy[1] === 1'b1 && q1.size() > 0) void'(q1.pop_front());
                n++;
            end
            cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s timeout got %0d left want 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        req_en = 2'b00; mem_rdy = 1'b0;
        q0.delete(); q1.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_en = 2'b11; req_wr = 2'b11; req_addr = 48'h123456_ABCDEF;
        req_wdata = 16'hA55A; mem_rdy = 1'b1; mem_rdata = 8'h33;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({mem_en, mem_wr, mem_rburst, mem_wburst, req_rdy, mem_addr, mem_wdata} !== 38'd0) begin
                errors++; $display("FAIL reset_outputs got %h want 0",
                    {mem_en, mem_wr, mem_rburst, mem_wburst, req_rdy, mem_addr, mem_wdata});
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_wr, mem_rburst, mem_wburst, req_rdy, mem_addr, mem_wdata} !== 38'd0) begin
            errors++; $display("FAIL post_reset_outputs got %h want 0",
                {mem_en, mem_wr, mem_rburst, mem_wburst, req_rdy, mem_addr, mem_wdata});
        end
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 24'hABCDEF || mem_wdata !== 8'h5A || req_rdy !== 2'b00) begin
            errors++; $display("FAIL first_tie_grant got en=%b addr=%h wd=%h rdy=%b want 1 abcdef 5a 00",
                mem_en, mem_addr, mem_wdata, req_rdy);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        req_en = 2'b01; req_wr = 2'b00; req_addr = 48'h0; req_addr[23:0] = 24'h000100;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL single_latency got mem_en=%b want 0", mem_en);
        end
        @(posedge clk); #1;
        mem_rdy = 1'b1; mem_rdata = 8'h5A;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 24'h000100 || mem_rburst !== 1'b0) begin
            errors++; $display("FAIL single_request got en=%b addr=%h rb=%b want 1 000100 0", mem_en, mem_addr, mem_rburst);
        end
        checks++;
        if (req_rdy !== 2'b01 || req_rdata !== 8'h5A) begin
            errors++; $display("FAIL single_response got rdy=%b data=%h want 01 5a", req_rdy, req_rdata);
        end
        @(posedge clk); #1;
        req_en = 2'b00; mem_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_burst();
        push_dir(0, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b0);
        push_dir(0, 1'b0, 24'h000011, 8'h00, 1'b1, 1'b0);
        push_dir(0, 1'b0, 24'h000012, 8'h00, 1'b1, 1'b0);
        push_dir(0, 1'b0, 24'h000020, 8'h00, 1'b0, 1'b0);
        push_dir(0, 1'b1, 24'h000021, 8'h77, 1'b0, 1'b0);
        push_dir(0, 1'b1, 24'h000022, 8'h78, 1'b0, 1'b1);
        run_traffic("read_burst");
    endtask

    task automatic test_wrap();
        push_dir(0, 1'b0, 24'hFFFFFF, 8'h00, 1'b0, 1'b0);
        push_dir(0, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b0);
        run_traffic("wrap_read");
        push_dir(1, 1'b1, 24'h000040, 8'hC1, 1'b0, 1'b0);
        push_dir(1, 1'b1, 24'h000041, 8'hC2, 1'b0, 1'b1);
        run_traffic("wburst");
    endtask

    task automatic test_idle_release();
        logic [23:0] a;
        a = 24'($urandom_range(0, 24'hFFFFF0));
        push_dir(1, 1'b0, a, 8'h00, 1'b0, 1'b0);
        run_traffic("release_first");
        push_dir(1, 1'b0, a + 24'd1, 8'h00, 1'b0, 1'b0);
        run_traffic("release_second");
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        req_en = 2'b10; req_wr = 2'b00; req_addr = 48'h0; req_addr[47:24] = 24'h00ABC0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (mem_en === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || mem_addr !== 24'h00ABC0) begin
            errors++; $display("FAIL midreset_grant got found=%b addr=%h want 1 00abc0", found, mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_wr, mem_rburst, mem_wburst, req_rdy, mem_addr, mem_wdata} !== 38'd0) begin
            errors++; $display("FAIL midreset_outputs got %h want 0",
                {mem_en, mem_wr, mem_rburst, mem_wburst, req_rdy, mem_addr, mem_wdata});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req_en = 2'b00; mem_rdy = 1'b1; mem_rdata = 8'hC3;
        @(negedge clk);
        checks++;
        if (req_rdy !== 2'b00 || mem_en !== 1'b0) begin
            errors++; $display("FAIL late_rdy got rdy=%b en=%b want 00 0", req_rdy, mem_en);
        end
        @(posedge clk); #1;
        mem_rdy = 1'b0;
    endtask

    // Both requesters stream continuously from a fresh reset; completions come in alternating runs
    task automatic test_contention(input int iter);
        req_t l0[$];
        req_t l1[$];
        req_t r;
        int   n0, n1, i0, i1, take, own;
        do_reset();
        n0 = $urandom_range(MAXB, 3 * MAXB);
        n1 = $urandom_range(MAXB, 3 * MAXB);
        for (int k = 0; k < n0 + n1; k++) begin
            r.wr    = ($urandom_range(0, 3) == 0);
            r.wdata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r.addr = 24'hFFFFFF;
            else r.addr = 24'($urandom);
            if (k < n0) begin
                if (k > 0 && $urandom_range(0, 1) == 1) r.addr = l0[k - 1].addr + 24'd1;
                l0.push_back(r);
            end else begin
                if (k > n0 && $urandom_range(0, 1) == 1) r.addr = l1[k - n0 - 1].addr + 24'd1;
                l1.push_back(r);
            end
        end
        have_last = 1'b0;
        i0 = 0; i1 = 0; own = 0;
        while (i0 < n0 || i1 < n1) begin
            if (own == 0) begin
                take = n0 - i0;
                if (i1 < n1 && take > MAXB) take = MAXB;
                for (int k = 0; k < take; k++) begin model_add(0, l0[i0]); i0++; end
                own = 1;
            end else begin
                take = n1 - i1;
                if (i0 < n0 && take > MAXB) take = MAXB;
                for (int k = 0; k < take; k++) begin model_add(1, l1[i1]); i1++; end
                own = 0;
            end
        end
        run_traffic($sformatf("contention%0d", iter));
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_read_burst();
        test_wrap();
        test_idle_release();
        test_reset_mid();
        for (int it = 0; it < 4; it++) test_contention(it);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
